// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared definitions for the two-master Wishbone arbiter:
//   - arb_state_t        : arbiter FSM state (IDLE, OWN0, OWN1)
//   - WB_ARB_TIMEOUT_DEF : default slave wait limit, in cycles
//   - WB_ARB_CNT_W       : width of the slave wait counter
package wb_arb_pkg;

    localparam int WB_ARB_CNT_W       = 8;
    localparam int WB_ARB_TIMEOUT_DEF = 255;

    // Each owner state sets exactly one bit, so the one-hot grant vector
    // can be read straight off the state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout
//   Counts slave wait cycles for the current strobe and flags expiry.
//   Ports:
//     clk     : system clock
//     reset_n : asynchronous active-low reset
//     run     : owner strobe is high and the slave has not acked this cycle
//     clear   : zero the counter at the next edge
//     expired : combinational, high while running with count == TIMEOUT
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = WB_ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [WB_ARB_CNT_W-1:0] LIMIT = WB_ARB_CNT_W'(TIMEOUT);

    logic [WB_ARB_CNT_W-1:0] r_count;

    // Expiry is only meaningful on a cycle that is still waiting; a
    // coincident ack drops run and therefore suppresses it.
    assign expired = run && (r_count == LIMIT);

    // The counter restarts after expiry so that a master that keeps its
    // strobe up after an error gets a fresh wait window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || expired) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
//   Two-master Wishbone arbiter in front of a single slave, with
//   round-robin tie breaking and a per-strobe slave wait timeout.
//   Ports:
//     clk, reset_n                  : clock, asynchronous active-low reset
//     m0_cyc/stb/we, m0_addr/data   : master-0 request
//     m0_ack, m0_err, m0_rdata      : master-0 response
//     m1_*                          : master-1, same layout as m0_*
//     s_cyc/stb/we, s_addr/data     : request muxed to the slave
//     s_ack, s_rdata                : slave response
//     grant                         : one-hot owner (bit0 m0, bit1 m1, 00 idle)
//     dbg_state                     : raw FSM state, for observation only
//
//   Handshake: a master holds cyc for the whole bus tenure; each transfer is
//   stb high until the cycle in which ack (or err) is seen high, and that
//   cycle completes it. Ack and read data pass through combinationally from
//   the slave; only the owner ever sees ack or err.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = WB_ARB_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_data,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic [1:0]  dbg_state
);

    arb_state_t r_state;
    logic       r_last;      // master served most recently: 0 = m0, 1 = m1

    logic       w_own0;
    logic       w_own1;
    logic       w_run;
    logic       w_expired;

    assign w_own0    = (r_state == OWN0);
    assign w_own1    = (r_state == OWN1);
    assign grant     = {w_own1, w_own0};
    assign dbg_state = r_state;

    // Slave-side request follows the owner's inputs directly, so a master
    // dropping cyc removes s_cyc in the same cycle.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_data = '0;
        if (w_own0) begin
            s_cyc  = m0_cyc;
            s_stb  = m0_stb;
            s_we   = m0_we;
            s_addr = m0_addr;
            s_data = m0_data;
        end else if (w_own1) begin
            s_cyc  = m1_cyc;
            s_stb  = m1_stb;
            s_we   = m1_we;
            s_addr = m1_addr;
            s_data = m1_data;
        end
    end

    assign m0_ack   = s_ack && w_own0 && m0_stb;
    assign m1_ack   = s_ack && w_own1 && m1_stb;
    assign m0_rdata = w_own0 ? s_rdata : '0;
    assign m1_rdata = w_own1 ? s_rdata : '0;

    // s_stb is already zero in IDLE, so run only counts an owner's wait.
    assign w_run = s_stb && !s_ack;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_run),
        .clear   (!w_run),
        .expired (w_expired)
    );

    assign m0_err = w_expired && w_own0;
    assign m1_err = w_expired && w_own1;

    // Release always passes through IDLE, which gives one dead cycle
    // between owners and a single place to apply round-robin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc && m1_cyc) begin
                        r_state <= r_last ? OWN0 : OWN1;
                    end else if (m0_cyc) begin
                        r_state <= OWN0;
                    end else if (m1_cyc) begin
                        r_state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!m0_cyc) begin
                        r_state <= IDLE;
                        r_last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc) begin
                        r_state <= IDLE;
                        r_last  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a reference
// model built from the arbitration rules.
module tb_wb_arbiter_2m;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_data;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;

  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_data;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_data;
  logic        s_ack;
  logic [31:0] s_rdata;

  logic [1:0]  grant;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  wb_arbiter_2m #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_data(m0_data),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_data(m1_data),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_data(s_data),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .grant(grant), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 = m0, 1 = m1, 2 = nobody. wait = cycles the current strobe has
  // waited without ack.
  int md_owner = 2;
  int md_last  = 1;
  int md_wait  = 0;

  function automatic logic sel_cyc(input int who);
    return (who == 0) ? m0_cyc : (who == 1) ? m1_cyc : 1'b0;
  endfunction
  function automatic logic sel_stb(input int who);
    return (who == 0) ? m0_stb : (who == 1) ? m1_stb : 1'b0;
  endfunction
  function automatic logic sel_we(input int who);
    return (who == 0) ? m0_we : (who == 1) ? m1_we : 1'b0;
  endfunction
  function automatic logic [31:0] sel_addr(input int who);
    return (who == 0) ? m0_addr : (who == 1) ? m1_addr : 32'h0;
  endfunction
  function automatic logic [31:0] sel_data(input int who);
    return (who == 0) ? m0_data : (who == 1) ? m1_data : 32'h0;
  endfunction
  function automatic logic waiting();
    return (md_owner != 2) && sel_stb(md_owner) && !s_ack;
  endfunction
  function automatic logic err_exp(input int who);
    return (md_owner == who) && waiting() && (md_wait == TMO);
  endfunction
  function automatic logic [1:0] grant_exp();
    return (md_owner == 0) ? 2'b01 : (md_owner == 1) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_owner <= 2;
      md_last  <= 1;
      md_wait  <= 0;
    end else if (md_owner == 2) begin
      md_wait <= 0;
      if (m0_cyc && m1_cyc) md_owner <= (md_last == 0) ? 1 : 0;
      else if (m0_cyc)      md_owner <= 0;
      else if (m1_cyc)      md_owner <= 1;
    end else begin
      if (!sel_cyc(md_owner)) begin
        md_owner <= 2;
        md_last  <= md_owner;
      end
      if (waiting() && md_wait < TMO) md_wait <= md_wait + 1;
      else                            md_wait <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cmp_grant",  {30'd0, grant}, {30'd0, grant_exp()});
    chk("cmp_s_cyc",  s_cyc,  sel_cyc(md_owner));
    chk("cmp_s_stb",  s_stb,  sel_stb(md_owner));
    chk("cmp_s_we",   s_we,   sel_we(md_owner));
    chk("cmp_s_addr", s_addr, sel_addr(md_owner));
    chk("cmp_s_data", s_data, sel_data(md_owner));
    chk("cmp_m0_ack", m0_ack, s_ack && md_owner == 0 && m0_stb);
    chk("cmp_m1_ack", m1_ack, s_ack && md_owner == 1 && m1_stb);
    chk("cmp_m0_err", m0_err, err_exp(0));
    chk("cmp_m1_err", m1_err, err_exp(1));
    chk("cmp_m0_rdata", m0_rdata, (md_owner == 0) ? s_rdata : 32'h0);
    chk("cmp_m1_rdata", m1_rdata, (md_owner == 1) ? s_rdata : 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 0; m0_data = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 0; m1_data = 0;
    s_ack = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit deaf;
    clr_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #3;
    // held in reset with the slave acking: nothing may reach a master
    s_ack = 1;
    settle();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_err", m1_err, 0);
    s_ack = 0;
    @(posedge clk);
    #3;
    reset_n = 1;

    // single write from m0, slave acks on its second cycle
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1;
    m0_addr = 32'h3000_0000; m0_data = 32'h0000_000A;
    settle();
    chk("wr_scyc_c0", s_cyc, 0);
    next_cycle(); settle();
    chk("wr_scyc_c1", s_cyc, 1);
    chk("wr_grant_c1", {30'd0, grant}, 32'd1);
    chk("wr_addr", s_addr, 32'h3000_0000);
    chk("wr_data", s_data, 32'h0000_000A);
    chk("wr_we", s_we, 1);
    chk("wr_ack_c1", m0_ack, 0);
    next_cycle(); s_ack = 1; settle();
    chk("wr_ack_c2", m0_ack, 1);
    chk("wr_m1_ack_c2", m1_ack, 0);
    next_cycle(); s_ack = 0; m0_cyc = 0; m0_stb = 0; settle();
    chk("wr_ack_c3", m0_ack, 0);
    chk("wr_scyc_drop", s_cyc, 0);
    next_cycle(); settle();
    chk("wr_grant_idle", {30'd0, grant}, 32'd0);

    // tie after reset, dead cycle, then second tie returns to m0
    do_reset();
    next_cycle();
    m0_cyc = 1; m1_cyc = 1;
    next_cycle(); settle();
    chk("tie_first", {30'd0, grant}, 32'd1);
    next_cycle(); m0_cyc = 0; settle();
    chk("tie_hold_drop", {30'd0, grant}, 32'd1);
    next_cycle(); settle();
    chk("tie_dead", {30'd0, grant}, 32'd0);
    next_cycle(); settle();
    chk("tie_m1", {30'd0, grant}, 32'd2);
    next_cycle(); m1_cyc = 0;
    next_cycle(); m0_cyc = 1; m1_cyc = 1; settle();
    chk("tie2_idle", {30'd0, grant}, 32'd0);
    next_cycle(); settle();
    chk("tie2_m0", {30'd0, grant}, 32'd1);
    next_cycle(); clr_inputs();
    next_cycle();

    // m1 holds the bus through three reads while m0 asks
    m1_cyc = 1;
    next_cycle(); settle();
    chk("hold_grant", {30'd0, grant}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      m0_cyc = 1; m0_stb = 1;
      m1_stb = 1; m1_we = 0; m1_addr = 32'h3000_0004 + i;
      s_ack = 1; rd = $urandom; s_rdata = rd;
      exp_q.push_back(rd);
      settle();
      chk("hold_grant_rd", {30'd0, grant}, 32'd2);
      chk("hold_m1_ack", m1_ack, 1);
      chk("hold_m1_rdata", m1_rdata, exp_q.pop_front());
      chk("hold_m0_ack", m0_ack, 0);
      chk("hold_m0_rdata", m0_rdata, 0);
    end
    next_cycle(); m1_cyc = 0; m1_stb = 0; s_ack = 0; settle();
    chk("hold_last", {30'd0, grant}, 32'd2);
    next_cycle(); settle();
    chk("hold_release", {30'd0, grant}, 32'd0);
    m0_cyc = 0; m0_stb = 0;
    next_cycle();

    // timeout with a silent slave
    m0_cyc = 1; m0_stb = 1;
    for (int c = 0; c < 9; c++) begin
      settle();
      chk("tmo_err", m0_err, (c == 5) ? 1 : 0);
      chk("tmo_ack", m0_ack, 0);
      chk("tmo_grant", {30'd0, grant}, (c == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    m0_cyc = 0; m0_stb = 0; settle();
    chk("tmo_grant_drop", {30'd0, grant}, 32'd1);
    chk("tmo_err_drop", m0_err, 0);
    next_cycle(); settle();
    chk("tmo_idle", {30'd0, grant}, 32'd0);

    // ack arriving on the expiry cycle wins
    m0_cyc = 1; m0_stb = 1;
    for (int c = 1; c < 5; c++) next_cycle();
    next_cycle(); s_ack = 1; settle();
    chk("coin_ack", m0_ack, 1);
    chk("coin_err", m0_err, 0);
    next_cycle(); clr_inputs();
    next_cycle();

    // reset while m1 has a strobe outstanding
    m1_cyc = 1; m1_stb = 1;
    next_cycle(); s_ack = 1; settle();
    chk("rmid_ack_pre", m1_ack, 1);
    chk("rmid_grant_pre", {30'd0, grant}, 32'd2);
    reset_n = 0;
    #1;
    chk("rmid_grant", {30'd0, grant}, 32'd0);
    chk("rmid_s_cyc", s_cyc, 0);
    chk("rmid_s_stb", s_stb, 0);
    chk("rmid_m1_ack", m1_ack, 0);
    m0_cyc = 1; s_ack = 0;
    @(posedge clk);
    #3;
    reset_n = 1;
    settle();
    chk("rmid_after_rel", {30'd0, grant}, 32'd0);
    next_cycle(); settle();
    chk("rmid_tie_m0", {30'd0, grant}, 32'd1);
    next_cycle(); clr_inputs();
    next_cycle();

    // randomized traffic, checked by the per-cycle compare
    deaf = 0;
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      if (n % 200 == 0) deaf = ($urandom_range(0, 2) == 0);
      if (!m0_cyc) m0_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 9) == 0) m0_cyc = 0;
      if (!m1_cyc) m1_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 9) == 0) m1_cyc = 0;
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_we = $urandom_range(0, 1); m0_addr = $urandom; m0_data = $urandom;
      m1_we = $urandom_range(0, 1); m1_addr = $urandom; m1_data = $urandom;
      s_ack = !deaf && ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset_n = 0;
        @(posedge clk);
        #2;
        reset_n = 1;
      end
    end

    next_cycle(); clr_inputs();
    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of slave wait cycles per strobe before an error is raised (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports m0_cyc, m0_stb, m0_we, inputs, 1 each, master-0 Wishbone cycle, strobe and write enable.
REQ-005 The block SHALL have ports m0_addr and m0_data, inputs, 32 each, master-0 address and write data.
REQ-006 The block SHALL have ports m0_ack and m0_err, outputs, 1 each, master-0 acknowledge and timeout error.
REQ-007 The block SHALL have port m0_rdata, output, 32, master-0 read data.
REQ-008 The block SHALL have master-1 ports m1_* identical in name pattern, direction and width to REQ-004..REQ-007.
REQ-009 The block SHALL have ports s_cyc, s_stb, s_we, outputs, 1 each, and s_addr and s_data, outputs, 32 each, driving the shared slave (the buttons/LEDs peripheral).
REQ-010 The block SHALL have ports s_ack, input, 1, and s_rdata, input, 32, carrying the slave response.
REQ-011 The block SHALL have port grant, output, 2, one-hot current owner (bit0 = m0, bit1 = m1; 00 = idle).

Function
REQ-012 The FSM SHALL have states IDLE, OWN0 and OWN1, held in a registered state variable; grant SHALL decode directly from that state.
REQ-013 In IDLE, if exactly one mN_cyc is high, the FSM SHALL enter OWNN on the next edge.
REQ-014 In IDLE, if both mN_cyc are high, the FSM SHALL grant the master not served last (round-robin); the last-served register SHALL reset to m1, so m0 wins the first tie.
REQ-015 In OWNN, the grant SHALL be held while mN_cyc stays high, regardless of the other master's requests.
REQ-016 In OWNN, when mN_cyc is low, the FSM SHALL return to IDLE, leaving one dead cycle before any re-grant; last-served SHALL update to N.
REQ-017 The s_cyc, s_stb, s_we, s_addr and s_data outputs SHALL be combinationally muxed from the owner's inputs; in IDLE they SHALL all be 0.
REQ-018 mN_ack SHALL equal s_ack AND (owner==N) AND mN_stb; the non-owner SHALL never see ack or err.
REQ-019 mN_rdata SHALL equal s_rdata when N owns the bus, else 0.
REQ-020 Latency SHALL be one cycle from request in IDLE to s_cyc/s_stb asserted; there SHALL be zero added latency on ack or rdata.
REQ-021 An 8-bit wait counter SHALL increment each cycle the owner's stb is high without s_ack, and SHALL clear on s_ack, on stb low, or in IDLE.
REQ-022 When the wait counter equals TIMEOUT with stb high and no s_ack, the owner's mN_err SHALL pulse for one cycle and the counter SHALL clear; the grant SHALL remain until the master drops cyc.
REQ-023 If s_ack and the timeout coincide, ack SHALL win and err SHALL NOT assert.
REQ-024 A master dropping cyc mid-wait SHALL abort its transfer; s_cyc SHALL fall combinationally that same cycle.

Reset
REQ-025 Asserting reset_n low SHALL immediately force state=IDLE, grant=00, wait counter=0 and last-served=m1; s_cyc, s_stb, all ack and all err outputs SHALL go to 0 without waiting for clk, including during an active transfer.
REQ-026 After reset_n deasserts, arbitration SHALL resume on the first rising edge.

Structure
REQ-027 The state encoding (IDLE, OWN0, OWN1), the default TIMEOUT value and the counter width SHALL live in shared package wb_arb_pkg.
REQ-028 The wait counter and its timeout compare SHALL be a single sub-module, wb_arb_timeout (inputs clk, reset_n, run, clear; output expired).
REQ-029 The RTL SHALL be 120-400 lines with no latches.

Verification
REQ-030 Single request: m0 write to addr 0x30000000, data 0x0000000A, slave acks in 2 cycles -> s_cyc high 1 cycle after m0_cyc, m0_ack is a single pulse, m1_ack stays 0.
REQ-031 Tie: m0_cyc and m1_cyc both rise in the same cycle after reset -> grant=01 first; after m0 drops cyc, one idle cycle, then grant=10; the next tie goes to m0.
REQ-032 Hold: m1 owns the bus and issues 3 back-to-back reads while m0 requests -> grant stays 10 until m1_cyc falls, and m0 is never acked.
REQ-033 Timeout: TIMEOUT=4, slave never acks -> m0_err pulses exactly once, 5 cycles after stb rises, m0_ack stays 0, and grant is held until cyc drops.
REQ-034 Ack/timeout coincidence: s_ack arrives on the expiry cycle -> ack=1 and err=0.
REQ-035 Reset mid-transfer: pull reset_n low while grant=10 with stb pending -> grant=00 and s_cyc=0 within the same cycle; after release, m0 wins the next tie.
